// File: rtl/sonic_echo_responder.sv
// HC-SR04-style ultrasonic sensor responder: validates a trigger pulse, waits out
// the burst time, then returns an echo pulse whose width encodes distance_cm.
module sonic_echo_responder #(
    parameter int US_DIV      = 100,
    parameter int TRIG_MIN_US = 10,
    parameter int BURST_US    = 200,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       trig_err,
    output logic       meas_done
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] TRIG_HI = 3'd1;
    localparam logic [2:0] BURST   = 3'd2;
    localparam logic [2:0] ECHO    = 3'd3;
    localparam logic [2:0] HOLDOFF = 3'd4;

    localparam int PW        = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int WIDTH_MIN = TRIG_MIN_US * US_DIV;
    localparam int WW        = $clog2(WIDTH_MIN + 1);

    localparam logic [PW-1:0] PRE_LAST    = PW'(US_DIV - 1);
    localparam logic [WW-1:0] WIDTH_SAT   = WW'(WIDTH_MIN);
    // The rise cycle itself is high but not counted, hence one less.
    localparam logic [WW-1:0] WIDTH_OK    = WW'(WIDTH_MIN - 1);
    localparam logic [15:0]   BURST_LAST  = 16'(BURST_US - 1);
    localparam logic [15:0]   HOLD_LAST   = 16'(HOLDOFF_US - 1);
    localparam logic [15:0]   TIMEOUT_VAL = 16'(TIMEOUT_US);

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic          trig_q;
    logic [PW-1:0] pre_cnt;
    logic [15:0]   us_cnt;
    logic [15:0]   echo_us;
    logic [15:0]   echo_us_calc;
    logic [WW-1:0] width_cnt;
    logic          us_tick;
    logic          trig_rise;
    logic          trig_fall;
    logic          width_ok;
    logic          short_trig;

    assign trig_rise = trig & ~trig_q;
    assign trig_fall = ~trig & trig_q;
    assign us_tick   = (pre_cnt == PRE_LAST);
    assign width_ok  = (width_cnt >= WIDTH_OK);

    always_comb begin
        if (distance_cm >= 9'd2 && distance_cm <= 9'd400)
            echo_us_calc = 16'(distance_cm) * 16'd58;
        else
            echo_us_calc = TIMEOUT_VAL;
    end

    always_comb begin
        state_next = state;
        short_trig = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (trig_rise) state_next = TRIG_HI;
                TRIG_HI: begin
                    if (trig_fall) begin
                        if (width_ok) begin
                            state_next = BURST;
                        end else begin
                            state_next = IDLE;
                            short_trig = 1'b1;
                        end
                    end
                end
                BURST:   if (us_tick && us_cnt == BURST_LAST) state_next = ECHO;
                ECHO:    if (us_tick && us_cnt == echo_us - 16'd1) state_next = HOLDOFF;
                HOLDOFF: if (us_tick && us_cnt == HOLD_LAST) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // trig_q resets high so a trigger held across reset release is not a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            trig_q    <= 1'b1;
            pre_cnt   <= '0;
            us_cnt    <= '0;
            width_cnt <= '0;
            echo_us   <= '0;
            echo      <= 1'b0;
            busy      <= 1'b0;
            trig_err  <= 1'b0;
            meas_done <= 1'b0;
        end else begin
            trig_q <= trig;
            state  <= state_next;
            if (state_next != state) begin
                pre_cnt <= '0;
                us_cnt  <= '0;
            end else begin
                pre_cnt <= us_tick ? '0 : pre_cnt + PW'(1);
                if (us_tick)
                    us_cnt <= us_cnt + 16'd1;
            end
            if (state == IDLE)
                width_cnt <= '0;
            else if (state == TRIG_HI && trig && width_cnt != WIDTH_SAT)
                width_cnt <= width_cnt + WW'(1);
            if (state == TRIG_HI && state_next == BURST)
                echo_us <= echo_us_calc;
            echo      <= (state_next == ECHO);
            busy      <= (state_next != IDLE);
            trig_err  <= short_trig;
            meas_done <= (state == ECHO) && (state_next == HOLDOFF);
        end
    end

endmodule

// File: tb/tb_sonic_echo_responder.sv
// Randomized scoreboard bench for sonic_echo_responder: stimulus pushes expected
// echo/error events, a negedge monitor pops and checks them as the DUT responds.
module tb_sonic_echo_responder;

    localparam int US_DIV      = 2;
    localparam int TRIG_MIN_US = 5;
    localparam int BURST_US    = 20;
    localparam int TIMEOUT_US  = 300;
    localparam int HOLDOFF_US  = 30;

    localparam int MIN_CLK   = TRIG_MIN_US * US_DIV;
    localparam int BURST_CLK = BURST_US * US_DIV;
    localparam int HOLD_CLK  = HOLDOFF_US * US_DIV;

    typedef struct {
        bit     is_err;
        longint fall_edge;
        longint width;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       trig;
    logic [8:0] distance_cm;
    logic       echo;
    logic       busy;
    logic       trig_err;
    logic       meas_done;

    int     tests = 0;
    int     failures = 0;
    longint cyc = 0;
    longint abort_at = -1;
    exp_t   exp_q[$];

    exp_t   cur;
    longint echo_start = 0;
    longint echo_fall = 0;
    bit     busy_pending = 0;
    logic   prev_echo = 1'b0;
    logic   prev_err = 1'b0;

    sonic_echo_responder #(
        .US_DIV(US_DIV), .TRIG_MIN_US(TRIG_MIN_US), .BURST_US(BURST_US),
        .TIMEOUT_US(TIMEOUT_US), .HOLDOFF_US(HOLDOFF_US)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .trig(trig),
        .distance_cm(distance_cm), .echo(echo), .busy(busy),
        .trig_err(trig_err), .meas_done(meas_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: echo width in clocks straight from the distance rule.
    function automatic longint echo_clocks(input int d);
        if (d >= 2 && d <= 400) return longint'(d) * 58 * US_DIV;
        return longint'(TIMEOUT_US) * US_DIV;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Issue one trigger high for hi_cycles sampled clocks with distance d.
    task automatic applyStimulus(input int hi_cycles, input int d, input bit expect_resp);
        exp_t e;
        @(posedge clk); #1;
        trig = 1'b1;
        distance_cm = 9'(d);
        repeat (hi_cycles) @(posedge clk);
        #1;
        trig = 1'b0;
        if (expect_resp) begin
            e.fall_edge = cyc + 1;
            e.is_err    = (hi_cycles < MIN_CLK);
            e.width     = e.is_err ? 0 : echo_clocks(d);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        distance_cm = 9'($urandom_range(0, 511));
    endtask

    task automatic waitEcho(input logic lvl, input int limit);
        int n = 0;
        while (echo !== lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_echo_level", longint'(echo), longint'(lvl));
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0 || busy_pending) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_idle_timeout", longint'(n >= limit), 0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: compares DUT events against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (prev_echo && abort_at >= 0) begin
                checkOutput("reset_abort_cycle", cyc, abort_at);
                abort_at = -1;
            end
            checkOutput("reset_echo", longint'(echo), 0);
            checkOutput("reset_busy", longint'(busy), 0);
            checkOutput("reset_trig_err", longint'(trig_err), 0);
            checkOutput("reset_meas_done", longint'(meas_done), 0);
            busy_pending = 0;
            prev_echo = 1'b0;
            prev_err = 1'b0;
        end else begin
            if (echo && !prev_echo) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_echo", 1, 0);
                    cur.width = -1;
                    echo_start = cyc;
                end else begin
                    cur = exp_q.pop_front();
                    checkOutput("echo_kind_is_err", longint'(cur.is_err), 0);
                    checkOutput("echo_rise_delay", cyc - cur.fall_edge, BURST_CLK);
                    echo_start = cyc;
                end
            end
            if (!echo && prev_echo) begin
                if (abort_at >= 0) begin
                    checkOutput("enable_abort_cycle", cyc, abort_at);
                    checkOutput("abort_meas_done", longint'(meas_done), 0);
                    checkOutput("abort_busy", longint'(busy), 0);
                    abort_at = -1;
                end else begin
                    checkOutput("echo_width", cyc - echo_start, cur.width);
                    checkOutput("meas_done_on_fall", longint'(meas_done), 1);
                    echo_fall = cyc;
                    busy_pending = 1;
                end
            end else if (meas_done) begin
                checkOutput("spurious_meas_done", 1, 0);
            end
            if (trig_err) begin
                if (prev_err) begin
                    checkOutput("trig_err_one_cycle", 1, 0);
                end else if (exp_q.size() == 0) begin
                    checkOutput("unexpected_trig_err", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    checkOutput("err_kind_is_err", longint'(cur.is_err), 1);
                    checkOutput("trig_err_cycle", cyc, cur.fall_edge);
                    checkOutput("busy_after_err", longint'(busy), 0);
                end
            end
            if (busy_pending && !busy) begin
                checkOutput("holdoff_length", cyc - echo_fall, HOLD_CLK);
                busy_pending = 0;
            end
            prev_echo = echo;
            prev_err = trig_err;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, expected < 200000", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        enable = 1'b1;
        trig = 1'b1;
        distance_cm = 9'd10;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        // Trigger held across reset release must not start a measurement.
        repeat (3 * MIN_CLK) @(posedge clk);
        #1 trig = 1'b0;
        repeat (20) @(posedge clk);
        checkOutput("no_echo_after_held_trig", longint'(busy), 0);

        applyStimulus(MIN_CLK, 10, 1);
        waitIdle(60000);
        applyStimulus(MIN_CLK - 1, 10, 1);
        waitIdle(60000);

        applyStimulus(MIN_CLK, 401, 1);
        waitIdle(60000);
        applyStimulus(MIN_CLK, 0, 1);
        waitIdle(60000);
        applyStimulus(MIN_CLK + 3, 1, 1);
        waitIdle(60000);
        applyStimulus(MIN_CLK, 2, 1);
        waitIdle(60000);
        applyStimulus(MIN_CLK, 400, 1);
        waitIdle(60000);

        // Trigger activity during BURST, ECHO and HOLDOFF is ignored.
        applyStimulus(MIN_CLK + 2, 15, 1);
        repeat (5) @(posedge clk);
        applyStimulus(MIN_CLK + 2, 300, 0);
        waitEcho(1'b1, 10000);
        repeat (100) @(posedge clk);
        applyStimulus(MIN_CLK + 2, 300, 0);
        waitEcho(1'b0, 10000);
        repeat (5) @(posedge clk);
        applyStimulus(MIN_CLK + 2, 20, 0);
        waitIdle(60000);

        for (int i = 0; i < 6; i++) begin
            int r;
            int d;
            r = int'($urandom_range(0, 9));
            if (r == 0)      d = int'($urandom_range(0, 1));
            else if (r == 1) d = int'($urandom_range(401, 511));
            else             d = int'($urandom_range(2, 20));
            applyStimulus(int'($urandom_range(MIN_CLK - 2, MIN_CLK + 8)), d, 1);
            waitIdle(60000);
        end

        // Asynchronous reset in the middle of an echo.
        applyStimulus(MIN_CLK, 20, 1);
        waitEcho(1'b1, 10000);
        repeat (300) @(posedge clk);
        #1;
        abort_at = cyc;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        waitIdle(60000);

        // enable dropped in the middle of an echo.
        applyStimulus(MIN_CLK, 20, 1);
        waitEcho(1'b1, 10000);
        repeat (300) @(posedge clk);
        #1;
        abort_at = cyc + 1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 enable = 1'b1;
        waitIdle(60000);

        applyStimulus(MIN_CLK + 1, 12, 1);
        waitIdle(60000);

        checkOutput("scoreboard_empty", longint'(exp_q.size()), 0);
        checkOutput("abort_consumed", abort_at, -1);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
